// File: rtl/encoder.sv
// Priority (MSB-wins) binary encoder with enable and registered outputs.
// A result for the vector sampled at one edge appears on the outputs after that edge.
module encoder #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         a,
    output logic [$clog2(N)-1:0] op,
    output logic                 valid,
    output logic                 multi
);

    localparam int OP_SIZE = $clog2(N);

    // Highest set index wins; the upward scan lets later (higher) hits overwrite earlier ones.
    function automatic logic [OP_SIZE-1:0] msb_index(input logic [N-1:0] v);
        logic [OP_SIZE-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = OP_SIZE'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic is_multi_hot(input logic [N-1:0] v);
        return |(v & (v - N'(1)));
    endfunction

    logic [OP_SIZE-1:0] op_p0;
    logic               vld_p0;
    logic               multi_p0;

    logic [OP_SIZE-1:0] op_p1;
    logic               vld_p1;
    logic               multi_p1;

    // Stage p0: combinational encode, gated by en so a is never observed while disabled
    always_comb begin
        op_p0    = '0;
        vld_p0   = 1'b0;
        multi_p0 = 1'b0;
        if (en) begin
            op_p0    = msb_index(a);
            vld_p0   = |a;
            multi_p0 = is_multi_hot(a);
        end
    end

    // Stage p1: output registers; reset clears the index too so op is known from the first edge
    always_ff @(posedge clk) begin
        if (rst) begin
            op_p1    <= '0;
            vld_p1   <= 1'b0;
            multi_p1 <= 1'b0;
        end else begin
            op_p1    <= op_p0;
            vld_p1   <= vld_p0;
            multi_p1 <= multi_p0;
        end
    end

    assign op    = op_p1;
    assign valid = vld_p1;
    assign multi = multi_p1;

endmodule

// File: tb/tb_encoder.sv
// Directed bench for the encoder: one N=4 instance and one N=5 instance,
// expectations hand-computed for each step.
module tb_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] a4  = '0;
    logic [4:0] a5  = '0;

    logic [1:0] op4;
    logic       valid4;
    logic       multi4;
    logic [2:0] op5;
    logic       valid5;
    logic       multi5;

    int total = 0;
    int bad   = 0;

    encoder #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a4),
        .op    (op4),
        .valid (valid4),
        .multi (multi4)
    );

    encoder #(.N(5)) dut5 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a5),
        .op    (op5),
        .valid (valid5),
        .multi (multi5)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [3:0] v4, input logic [4:0] v5);
        rst = r;
        en  = e;
        a4  = v4;
        a5  = v5;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [1:0] eop, input logic ev, input logic em);
        check({tag, ".op"},    8'(op4),    8'(eop));
        check({tag, ".valid"}, 8'(valid4), 8'(ev));
        check({tag, ".multi"}, 8'(multi4), 8'(em));
    endtask

    task automatic check5(input string tag, input logic [2:0] eop, input logic ev, input logic em);
        check({tag, ".op"},    8'(op5),    8'(eop));
        check({tag, ".valid"}, 8'(valid5), 8'(ev));
        check({tag, ".multi"}, 8'(multi5), 8'(em));
    endtask

    initial begin
        // Reset held two edges with a live request present
        step(1'b1, 1'b1, 4'b1000, 5'b10000);
        check4("rst1", 2'd0, 1'b0, 1'b0);
        check5("rst1_n5", 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b1000, 5'b10000);
        check4("rst2", 2'd0, 1'b0, 1'b0);
        check5("rst2_n5", 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1000, 5'b00000);
        check4("rst_release", 2'd3, 1'b1, 1'b0);

        // Disabled sweep
        step(1'b0, 1'b0, 4'b0001, 5'b00000); check4("dis0", 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0010, 5'b00000); check4("dis1", 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0100, 5'b00000); check4("dis2", 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b1000, 5'b11111); check4("dis3", 2'd0, 1'b0, 1'b0);
        check5("dis3_n5", 3'd0, 1'b0, 1'b0);

        // Enabled one-hot sweep
        step(1'b0, 1'b1, 4'b0001, 5'b00000); check4("oh0", 2'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b0010, 5'b00000); check4("oh1", 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 5'b00000); check4("oh2", 2'd2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b1000, 5'b00000); check4("oh3", 2'd3, 1'b1, 1'b0);

        // Priority and multi-hot
        step(1'b0, 1'b1, 4'b1011, 5'b00000); check4("pri1011", 2'd3, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 5'b00000); check4("pri0110", 2'd2, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'b0011, 5'b00000); check4("pri0011", 2'd1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 5'b00000); check4("zero",    2'd0, 1'b0, 1'b0);

        // Enable toggle and mid-stream reset
        step(1'b0, 1'b1, 4'b0100, 5'b00000); check4("tog_en",  2'd2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0100, 5'b00000); check4("tog_dis", 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1100, 5'b00000); check4("pre_rst", 2'd3, 1'b1, 1'b1);
        step(1'b1, 1'b1, 4'b0010, 5'b00000); check4("mid_rst", 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0010, 5'b00000); check4("post_rst", 2'd1, 1'b1, 1'b0);

        // Non-power-of-two width
        step(1'b0, 1'b1, 4'b0000, 5'b10000); check5("n5_10000", 3'd4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 5'b11111); check5("n5_11111", 3'd4, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 5'b00101); check5("n5_00101", 3'd2, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 5'b00001); check5("n5_00001", 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 5'b00000); check5("n5_zero",  3'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- Parameterised N-to-log2(N) binary encoder with enable and registered outputs.
- Converts a one-hot request vector into the binary index of the asserted bit.
- If more than one bit is set, the highest index wins, and the block flags the vector as not one-hot.
- Used wherever a one-hot select or grant vector must be compressed to an index for downstream muxing or addressing.

Parameters:
- N, default 4: width of the input vector. Legal for N >= 2; N need not be a power of two.
- OP_SIZE, derived localparam = $clog2(N): width of the encoded output. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  encode enable; sampled on the rising edge of clk
- a  input  N  input vector, nominally one-hot
- op  output  OP_SIZE  registered binary index of the highest set bit of a
- valid  output  1  registered; high when en was high and a was nonzero
- multi  output  1  registered; high when en was high and more than one bit of a was set

Behaviour:
- One clock, fully synchronous. Reset is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1: op=0, valid=0, multi=0.
  - rst takes priority over en.
  - Reset asserted mid-stream clears all outputs on that edge. No other state exists.
- Latency:
  - Outputs reflect en and a sampled at edge k and are visible after edge k.
  - One-cycle latency, one result per cycle, no handshake and no backpressure.
- Disabled:
  - On an edge with rst=0 and en=0: op=0, valid=0, multi=0, regardless of a.
- Enabled (en=1, rst=0), combinational encode registered at the edge:
  - op = largest index i in [0, N-1] with a[i]=1. This is priority encoding, MSB wins.
  - a = 0: op=0, valid=0, multi=0.
  - Exactly one bit set: op = its index, valid=1, multi=0.
  - Two or more bits set: op = highest set index, valid=1, multi=1.
- Width rules:
  - op is zero-extended to OP_SIZE bits.
  - When N is not a power of two, index values >= N never appear on op.
  - op=0 with valid=0 means "no request". op=0 with valid=1 means bit 0.
- Outputs hold their registered value between edges.
- No X propagation from a when en=0. Outputs must be known values from the first edge with rst=1.
- Input a is treated as synchronous to clk. No internal synchroniser.

Test Plan:
- Reset: hold rst=1 for 2 edges with en=1, a=4'b1000 -> op=0, valid=0, multi=0 after each edge. Release rst -> next edge gives op=3, valid=1.
- Disabled sweep (N=4): en=0, a = 0001, 0010, 0100, 1000, one per cycle -> op=0, valid=0, multi=0 every cycle.
- Enabled one-hot sweep (N=4): en=1, a = 0001, 0010, 0100, 1000 -> op = 0, 1, 2, 3 one cycle later, valid=1, multi=0.
- Priority and multi-hot (N=4): en=1, a=1011 -> op=3, valid=1, multi=1. a=0110 -> op=2, multi=1. a=0000 -> op=0, valid=0, multi=0.
- Enable toggle and mid-stream reset: en=1, a=0100 -> op=2. Next cycle en=0 -> op=0, valid=0. Then en=1, a=0010 with rst=1 on the same edge -> op=0, valid=0.
- Non-power-of-two (N=5, OP_SIZE=3): en=1, a=10000 -> op=4, valid=1. a=11111 -> op=4, multi=1.
